// File: rtl/serdes_wr_burst_arbiter.sv
// Round-robin burst arbiter sharing one AXI-style AW+W write channel between NUM_PORTS requesters.
// Optional W-stall watchdog compiled in with `define SERDES_ARB_WDOG_EN.
module serdes_wr_burst_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int MDATA_WIDTH  = 64,
    parameter int AWPORT_WIDTH = 2,
    parameter int AWLEN_WIDTH  = 16,
    parameter int AWSIZE_WIDTH = 16,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic                                  M_CLK_I,
    input  logic                                  M_RST_I,
    input  logic [NUM_PORTS*AWPORT_WIDTH-1:0]     S_AWPORT_I,
    input  logic [NUM_PORTS*AWLEN_WIDTH-1:0]      S_AWLEN_I,
    input  logic [NUM_PORTS*AWSIZE_WIDTH-1:0]     S_AWSIZE_I,
    input  logic [NUM_PORTS-1:0]                  S_AWVALID_I,
    output logic [NUM_PORTS-1:0]                  S_AWREADY_O,
    input  logic [NUM_PORTS*MDATA_WIDTH-1:0]      S_WDATA_I,
    input  logic [NUM_PORTS*MDATA_WIDTH/8-1:0]    S_WSTRB_I,
    input  logic [NUM_PORTS-1:0]                  S_WLAST_I,
    input  logic [NUM_PORTS-1:0]                  S_WVALID_I,
    output logic [NUM_PORTS-1:0]                  S_WREADY_O,
    output logic [AWPORT_WIDTH-1:0]               M_AWPORT,
    output logic [AWLEN_WIDTH-1:0]                M_AWLEN,
    output logic [AWSIZE_WIDTH-1:0]               M_AWSIZE,
    output logic [$clog2(NUM_PORTS)-1:0]          M_AWID,
    output logic                                  M_AWVALID,
    input  logic                                  M_AWREADY,
    output logic [MDATA_WIDTH-1:0]                M_WDATA,
    output logic [MDATA_WIDTH/8-1:0]              M_WSTRB,
    output logic                                  M_WLAST,
    output logic                                  M_WVALID,
    input  logic                                  M_WREADY,
    output logic [NUM_PORTS-1:0]                  GRANT_O,
    output logic                                  BUSY_O,
    output logic [2:0]                            ERR_O,
    output logic [31:0]                           BURST_CNT_O
);
    localparam int IDW = $clog2(NUM_PORTS);
    localparam int SW  = MDATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

    state_t                  state, state_nx;
    logic [IDW-1:0]          rr, rr_nx, pick, id_nx;
    logic                    found;
    logic [AWLEN_WIDTH-1:0]  cnt, cnt_nx, awlen_nx;
    logic [AWPORT_WIDTH-1:0] awport_nx;
    logic [AWSIZE_WIDTH-1:0] awsize_nx;
    logic [NUM_PORTS-1:0]    grant_nx;
    logic                    awv_nx;
    logic [2:0]              err_nx;
    logic [31:0]             bcnt_nx;
    logic                    wdog_hit;

    assign BUSY_O = (state != S_IDLE);

    // First requester after the last winner, with wraparound.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!found && S_AWVALID_I[(int'(rr) + k) % NUM_PORTS]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr) + k) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        S_AWREADY_O = '0;
        S_WREADY_O  = '0;
        M_WVALID    = 1'b0;
        M_WDATA     = '0;
        M_WSTRB     = '0;
        M_WLAST     = 1'b0;
        if (state == S_AW)
            S_AWREADY_O[M_AWID] = M_AWREADY & M_AWVALID;
        if (state == S_W) begin
            M_WVALID           = S_WVALID_I[M_AWID];
            S_WREADY_O[M_AWID] = M_WREADY;
            M_WDATA            = S_WDATA_I[M_AWID*MDATA_WIDTH +: MDATA_WIDTH];
            M_WSTRB            = S_WSTRB_I[M_AWID*SW +: SW];
            M_WLAST            = S_WLAST_I[M_AWID];
        end
    end

    always_comb begin
        state_nx  = state;
        rr_nx     = rr;
        cnt_nx    = cnt;
        id_nx     = M_AWID;
        grant_nx  = GRANT_O;
        awv_nx    = M_AWVALID;
        awport_nx = M_AWPORT;
        awlen_nx  = M_AWLEN;
        awsize_nx = M_AWSIZE;
        bcnt_nx   = BURST_CNT_O;
        err_nx    = ERR_O;
        err_nx[2] = ERR_O[2] | wdog_hit;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nx        = S_AW;
                    id_nx           = pick;
                    awport_nx       = S_AWPORT_I[pick*AWPORT_WIDTH +: AWPORT_WIDTH];
                    awlen_nx        = S_AWLEN_I[pick*AWLEN_WIDTH +: AWLEN_WIDTH];
                    awsize_nx       = S_AWSIZE_I[pick*AWSIZE_WIDTH +: AWSIZE_WIDTH];
                    grant_nx        = '0;
                    grant_nx[pick]  = 1'b1;
                    awv_nx          = 1'b1;
                end
            end
            S_AW: begin
                if (M_AWREADY) begin
                    awv_nx = 1'b0;
                    cnt_nx = M_AWLEN;
                    rr_nx  = M_AWID;
                    if (M_AWLEN != '0) begin
                        state_nx = S_W;
                    end else begin
                        // Zero-length burst has no W phase and is not counted.
                        state_nx  = S_IDLE;
                        grant_nx  = '0;
                        err_nx[1] = 1'b1;
                    end
                end
            end
            S_W: begin
                if (M_WVALID && M_WREADY) begin
                    cnt_nx = cnt - 1'b1;
                    // Either WLAST or the beat count closes the burst; a mismatch is flagged, never stretched.
                    if (M_WLAST || cnt == AWLEN_WIDTH'(1)) begin
                        state_nx = S_IDLE;
                        grant_nx = '0;
                        bcnt_nx  = BURST_CNT_O + 32'd1;
                        if (M_WLAST && cnt != AWLEN_WIDTH'(1))
                            err_nx[0] = 1'b1;
                        if (!M_WLAST)
                            err_nx[1] = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge M_CLK_I) begin
        if (M_RST_I) begin
            state       <= S_IDLE;
            rr          <= IDW'(NUM_PORTS - 1);
            cnt         <= '0;
            M_AWID      <= '0;
            GRANT_O     <= '0;
            M_AWVALID   <= 1'b0;
            M_AWPORT    <= '0;
            M_AWLEN     <= '0;
            M_AWSIZE    <= '0;
            ERR_O       <= '0;
            BURST_CNT_O <= '0;
        end else begin
            state       <= state_nx;
            rr          <= rr_nx;
            cnt         <= cnt_nx;
            M_AWID      <= id_nx;
            GRANT_O     <= grant_nx;
            M_AWVALID   <= awv_nx;
            M_AWPORT    <= awport_nx;
            M_AWLEN     <= awlen_nx;
            M_AWSIZE    <= awsize_nx;
            ERR_O       <= err_nx;
            BURST_CNT_O <= bcnt_nx;
        end
    end

`ifdef SERDES_ARB_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog;

    // Counts W-phase cycles with no valid beat; saturates, never aborts the burst.
    always_ff @(posedge M_CLK_I) begin
        if (M_RST_I || state != S_W || (M_WVALID && M_WREADY))
            wdog <= '0;
        else if (!M_WVALID && wdog != WDW'(WDOG_CYCLES))
            wdog <= wdog + 1'b1;
    end

    assign wdog_hit = (wdog == WDW'(WDOG_CYCLES));
`else
    assign wdog_hit = 1'b0;
`endif

endmodule

// File: doc/serdes_wr_burst_arbiter.md
Name: serdes_wr_burst_arbiter

Overview:
- Shares one downstream AXI4-style write channel (AW + W) between NUM_PORTS serdes-to-stream converter instances.
- Each requester issues one AW (beat count in AWLEN) followed by exactly that many W beats, the last one marked by WLAST.
- The arbiter grants whole bursts round-robin, locks the W mux to the granted port until the WLAST handshake, and checks beat count against AWLEN.
- Sits between the converter instances and the memory-side write master; everything runs in the master clock domain.

Parameters:
- NUM_PORTS, 4: number of requesters (2..8).
- MDATA_WIDTH, 64: W data width in bits; strobe width is MDATA_WIDTH/8.
- AWPORT_WIDTH, 2: AW port/tag field width.
- AWLEN_WIDTH, 16: burst length field width; the value is a beat count, not count-minus-one.
- AWSIZE_WIDTH, 16: AW size field width.
- WDOG_CYCLES, 1024: stall limit, used only with the optional feature.

Ports:
- M_CLK_I  in  1  single clock for the whole block.
- M_RST_I  in  1  synchronous, active-high reset.
- S_AWPORT_I  in  NUM_PORTS*AWPORT_WIDTH  per-port AW tag; port i occupies slice i.
- S_AWLEN_I  in  NUM_PORTS*AWLEN_WIDTH  per-port beat count.
- S_AWSIZE_I  in  NUM_PORTS*AWSIZE_WIDTH  per-port size.
- S_AWVALID_I  in  NUM_PORTS  AW request per port.
- S_AWREADY_O  out  NUM_PORTS  AW accept per port.
- S_WDATA_I  in  NUM_PORTS*MDATA_WIDTH  per-port W data.
- S_WSTRB_I  in  NUM_PORTS*MDATA_WIDTH/8  per-port W strobes.
- S_WLAST_I  in  NUM_PORTS  per-port last-beat marker.
- S_WVALID_I  in  NUM_PORTS  per-port W valid.
- S_WREADY_O  out  NUM_PORTS  per-port W ready.
- M_AWPORT  out  AWPORT_WIDTH  granted tag.
- M_AWLEN  out  AWLEN_WIDTH  granted beat count.
- M_AWSIZE  out  AWSIZE_WIDTH  granted size.
- M_AWID  out  clog2(NUM_PORTS)  index of the granted port.
- M_AWVALID  out  1  downstream AW valid.
- M_AWREADY  in  1  downstream AW ready.
- M_WDATA  out  MDATA_WIDTH  muxed W data.
- M_WSTRB  out  MDATA_WIDTH/8  muxed W strobes.
- M_WLAST  out  1  muxed W last.
- M_WVALID  out  1  muxed W valid.
- M_WREADY  in  1  downstream W ready.
- GRANT_O  out  NUM_PORTS  one-hot grant; zero when idle.
- BUSY_O  out  1  high whenever the state is not IDLE.
- ERR_O  out  3  sticky error flags: [0] early WLAST, [1] missing WLAST, [2] watchdog.
- BURST_CNT_O  out  32  count of completed bursts; wraps at 2^32.

Behaviour:
- Reset (sync, any state): state=IDLE, rr pointer=NUM_PORTS-1 (so port 0 wins first), GRANT_O=0, M_AWVALID=0, M_WVALID=0, all S_*READY_O=0, ERR_O=0, BURST_CNT_O=0, AW output regs=0. Reset mid-burst abandons the burst with no WLAST emitted.
- States:
  - IDLE: if any S_AWVALID_I is high, pick the first set bit searching from rr+1 with wraparound, then go to AW.
  - AW: hold the winner's request in the registered outputs.
  - W: forward the winner's W channel until the last beat completes.
- IDLE -> AW (same edge):
  - Register the winner's AWPORT/AWLEN/AWSIZE and its index to M_AWID.
  - Set GRANT_O and M_AWVALID=1.
  - Latency: a request sampled at edge t gives M_AWVALID high after edge t.
- AW behaviour:
  - S_AWREADY_O[g] = M_AWREADY & M_AWVALID, combinational.
  - M_AWVALID holds with stable fields until M_AWREADY.
  - On the handshake: M_AWVALID<=0, beat counter<=AWLEN, rr<=g.
  - If AWLEN!=0, go to W.
  - If AWLEN==0, return to IDLE, set ERR_O[1], and do not increment BURST_CNT_O.
- W behaviour (combinational mux of port g):
  - M_WVALID = S_WVALID_I[g].
  - S_WREADY_O[g] = M_WREADY.
  - Data, strobe and WLAST pass through unmodified.
  - All non-granted S_WREADY_O stay 0.
- On each W handshake the counter decrements.
- Handshake with WLAST and counter==1: normal end; go to IDLE, BURST_CNT_O+1, GRANT_O<=0.
- Handshake with WLAST and counter>1: set ERR_O[0], end the burst anyway (go to IDLE, count it).
- Handshake with counter==1 and no WLAST: set ERR_O[1], end the burst (go to IDLE, count it); the next beat from that port is not accepted until it is regranted.
- Simultaneous requests: only one grant per arbitration; the others wait.
- A port that drops AWVALID before the grant is not granted.
- Back-to-back: IDLE costs one cycle between bursts, so throughput is AWLEN+2 cycles per burst minimum with M_AWREADY and M_WREADY tied high.
- The arbiter never issues a second AW before the previous W burst completes (single outstanding).

Optional Feature:
- Macro SERDES_ARB_WDOG_EN.
- When defined:
  - In state W, a counter increments on each cycle where M_WVALID is 0; it clears on any handshake.
  - When it reaches WDOG_CYCLES, ERR_O[2] is set and the counter saturates.
  - No burst abort, because the AXI protocol forbids truncation.
- When undefined: no counter logic exists and ERR_O[2] is tied 0.

Test Plan:
- Port1 alone, AWLEN=4, ready high, 4 beats with WLAST on the 4th -> M_AWVALID 1 cycle after request; M_AWID=1; 4 W handshakes; BURST_CNT_O=1; ERR_O=0.
- Ports 0,2,3 requesting continuously, AWLEN=2 each -> grant order 0,2,3,0,2,3; no beat from a non-granted port reaches M_W*.
- M_AWREADY held low 5 cycles -> M_AWVALID and AW fields stable for 5 cycles; S_AWREADY_O pulses exactly once.
- Port0 AWLEN=3 asserts WLAST on beat 2 -> ERR_O=3'b001; state IDLE after beat 2; BURST_CNT_O incremented.
- Port0 AWLEN=0 -> AW handshake, no W phase, ERR_O[1]=1, BURST_CNT_O unchanged.
- SERDES_ARB_WDOG_EN with WDOG_CYCLES=16: granted port idles WVALID 16 cycles mid-burst -> ERR_O[2]=1; burst then completes normally. Separately, assert M_RST_I mid-burst -> all outputs return to reset values the next cycle.
